// File: rtl/water_cycle_controller.sv
// Fill-hold-drain sequencer for one washing-machine water cycle.
// Ports: clk/reset; start, target_level, abort, fault_clear,
//   water_level_sensor, flow_error in; inlet_valve, drain_pump,
//   monitor_mode, monitor_reset, busy, done, fault, fault_code,
//   state_out out.
module water_cycle_controller #(
  parameter int HOLD_CYCLES   = 20,
  parameter int EMPTY_LEVEL   = 10,
  parameter int LEVEL_MAX     = 1000,
  parameter int FILL_TIMEOUT  = 100,
  parameter int DRAIN_TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] target_level,
  input  logic       abort,
  input  logic       fault_clear,
  input  logic [9:0] water_level_sensor,
  input  logic       flow_error,
  output logic       inlet_valve,
  output logic       drain_pump,
  output logic       monitor_mode,
  output logic       monitor_reset,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL_INIT  = 3'd1,
    FILLING    = 3'd2,
    HOLD       = 3'd3,
    DRAIN_INIT = 3'd4,
    DRAINING   = 3'd5,
    DONE       = 3'd6,
    FAULT      = 3'd7
  } state_t;

  localparam logic [9:0]  L_EMPTY = 10'(EMPTY_LEVEL);
  localparam logic [9:0]  L_MAX   = 10'(LEVEL_MAX);
  localparam logic [15:0] L_HOLD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] L_FTO   = 16'(FILL_TIMEOUT - 1);
  localparam logic [15:0] L_DTO   = 16'(DRAIN_TIMEOUT - 1);

  state_t      r_state;
  logic [9:0]  r_target;
  logic [15:0] r_cnt;
  logic [1:0]  r_code;

  // Counter increments by default; every transition below
  // overrides it with zero (last non-blocking write wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_cnt    <= '0;
      r_code   <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_target <= target_level;
            r_cnt    <= '0;
            if (target_level <= L_EMPTY ||
                target_level > L_MAX) begin
              r_state <= FAULT;
              r_code  <= 2'd3;
            end else begin
              r_state <= FILL_INIT;
            end
          end
        end
        FILL_INIT: begin
          r_state <= FILLING;
          r_cnt   <= '0;
        end
        FILLING: begin
          if (flow_error) begin
            r_state <= FAULT;
            r_code  <= 2'd1;
            r_cnt   <= '0;
          end else if (abort) begin
            r_state <= DRAIN_INIT;
            r_cnt   <= '0;
          end else if (water_level_sensor >= r_target) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == L_FTO) begin
            r_state <= FAULT;
            r_code  <= 2'd2;
            r_cnt   <= '0;
          end
        end
        HOLD: begin
          if (abort || r_cnt == L_HOLD) begin
            r_state <= DRAIN_INIT;
            r_cnt   <= '0;
          end
        end
        DRAIN_INIT: begin
          r_state <= DRAINING;
          r_cnt   <= '0;
        end
        DRAINING: begin
          if (flow_error) begin
            r_state <= FAULT;
            r_code  <= 2'd1;
            r_cnt   <= '0;
          end else if (water_level_sensor <= L_EMPTY) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end else if (r_cnt == L_DTO) begin
            r_state <= FAULT;
            r_code  <= 2'd2;
            r_cnt   <= '0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        FAULT: begin
          if (fault_clear) begin
            r_state <= IDLE;
            r_code  <= 2'd0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Moore decodes straight off the state register, so an async
  // reset drops the valve and pump without waiting for a clock.
  assign inlet_valve   = (r_state == FILLING);
  assign drain_pump    = (r_state == DRAINING);
  assign monitor_mode  = (r_state == IDLE) || (r_state == FILL_INIT) ||
                         (r_state == FILLING) || (r_state == HOLD);
  assign monitor_reset = !((r_state == FILLING) ||
                           (r_state == DRAINING));
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign fault         = (r_state == FAULT);
  assign fault_code    = r_code;
  assign state_out     = r_state;

endmodule

// File: tb/tb_water_cycle_controller.sv
// Bench for water_cycle_controller: behavioural phase model,
// per-cycle output compare, and directed scenarios.
module tb_water_cycle_controller;

  localparam int HOLD_N  = 4;
  localparam int FILL_TO = 8;
  localparam int DRN_TO  = 30;
  localparam int EMPTY   = 10;
  localparam int LMAX    = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] target_level;
  logic       abort;
  logic       fault_clear;
  logic [9:0] sensor;
  logic       flow_error;
  logic       inlet_valve;
  logic       drain_pump;
  logic       monitor_mode;
  logic       monitor_reset;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  water_cycle_controller #(
    .HOLD_CYCLES  (HOLD_N),
    .EMPTY_LEVEL  (EMPTY),
    .LEVEL_MAX    (LMAX),
    .FILL_TIMEOUT (FILL_TO),
    .DRAIN_TIMEOUT(DRN_TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .target_level      (target_level),
    .abort             (abort),
    .fault_clear       (fault_clear),
    .water_level_sensor(sensor),
    .flow_error        (flow_error),
    .inlet_valve       (inlet_valve),
    .drain_pump        (drain_pump),
    .monitor_mode      (monitor_mode),
    .monitor_reset     (monitor_reset),
    .busy              (busy),
    .done              (done),
    .fault             (fault),
    .fault_code        (fault_code),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase number plus how many cycles it has lasted.
  int m_st   = 0;
  int m_cnt  = 0;
  int m_code = 0;
  int m_tgt  = 0;

  always @(posedge clk or posedge reset) begin
    int nx;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_code = 0; m_tgt = 0;
    end else begin
      nx = m_st;
      case (m_st)
        0: if (start) begin
          m_tgt = int'(target_level);
          if (m_tgt <= EMPTY || m_tgt > LMAX) begin
            nx = 7; m_code = 3;
          end else nx = 1;
        end
        1: nx = 2;
        2: begin
          if (flow_error) begin nx = 7; m_code = 1; end
          else if (abort) nx = 4;
          else if (int'(sensor) >= m_tgt) nx = 3;
          else if (m_cnt + 1 >= FILL_TO) begin nx = 7; m_code = 2; end
        end
        3: if (abort || m_cnt + 1 >= HOLD_N) nx = 4;
        4: nx = 5;
        5: begin
          if (flow_error) begin nx = 7; m_code = 1; end
          else if (int'(sensor) <= EMPTY) nx = 6;
          else if (m_cnt + 1 >= DRN_TO) begin nx = 7; m_code = 2; end
        end
        6: nx = 0;
        default: if (fault_clear) begin nx = 0; m_code = 0; end
      endcase
      m_cnt = (nx == m_st) ? m_cnt + 1 : 0;
      m_st  = nx;
    end
  end

  always @(negedge clk) begin
    check("state", int'(state_out), m_st);
    check("inlet_valve", int'(inlet_valve), int'(m_st == 2));
    check("drain_pump", int'(drain_pump), int'(m_st == 5));
    check("monitor_mode", int'(monitor_mode), int'(m_st <= 3));
    check("monitor_reset", int'(monitor_reset),
          int'(m_st != 2 && m_st != 5));
    check("busy", int'(busy), int'(m_st != 0));
    check("done", int'(done), int'(m_st == 6));
    check("fault", int'(fault), int'(m_st == 7));
    check("fault_code", int'(fault_code), m_code);
  end

  int n_valve, n_pump, n_hold, n_done;

  task automatic clr_cnt();
    n_valve = 0; n_pump = 0; n_hold = 0; n_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_valve += int'(inlet_valve);
    n_pump  += int'(drain_pump);
    n_hold  += int'(state_out == 3'd3);
    n_done  += int'(done);
  endtask

  task automatic wait_model(input int st, input int budget, input string nm);
    int k = 0;
    while (m_st != st && k < budget) begin
      tick();
      k++;
    end
    if (m_st != st) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, state %0d wanted %0d", nm, m_st, st);
    end
  endtask

  task automatic go(input int tgt);
    target_level = 10'(tgt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target_level = '0; abort = 1'b0;
    fault_clear = 1'b0; sensor = 10'd50; flow_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state_out), 0);
    check("rst_mreset", int'(monitor_reset), 1);
    check("rst_mmode", int'(monitor_mode), 1);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // Normal cycle; level reached on the same cycle as the timeout.
    clr_cnt();
    go(200);
    tick();
    for (int s = 70; s <= 210; s += 20) begin
      sensor = 10'(s);
      tick();
    end
    check("norm_hold", int'(state_out), 3);
    check("norm_valve_cycles", n_valve, 8);
    flow_error = 1'b1;
    tick();
    flow_error = 1'b0;
    repeat (3) tick();
    check("norm_drain_init", int'(state_out), 4);
    check("norm_hold_cycles", n_hold, 4);
    sensor = 10'd210;
    tick();
    abort = 1'b1;
    for (int s = 190; s >= 10; s -= 20) begin
      sensor = 10'(s);
      tick();
    end
    abort = 1'b0;
    check("norm_done", int'(done), 1);
    check("norm_pump_cycles", n_pump, 10);
    tick();
    check("norm_idle_busy", int'(busy), 0);
    check("norm_done_cycles", n_done, 1);

    // Fill timeout.
    clr_cnt();
    sensor = 10'd50;
    go(300);
    repeat (9) tick();
    check("fto_state", int'(state_out), 7);
    check("fto_code", int'(fault_code), 2);
    check("fto_valve_cycles", n_valve, 8);
    start = 1'b1; abort = 1'b1;
    repeat (3) tick();
    start = 1'b0; abort = 1'b0;
    check("fto_sticky", int'(state_out), 7);
    clear_fault();
    check("fto_cleared_state", int'(state_out), 0);
    check("fto_cleared_code", int'(fault_code), 0);

    // Abort in HOLD, then flow error while draining.
    sensor = 10'd250;
    go(200);
    wait_model(3, 10, "fe_hold");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sensor = 10'd150;
    wait_model(5, 5, "fe_drain");
    flow_error = 1'b1;
    tick();
    flow_error = 1'b0;
    check("fe_code", int'(fault_code), 1);
    check("fe_pump", int'(drain_pump), 0);
    clear_fault();

    // Abort while filling.
    clr_cnt();
    sensor = 10'd120;
    go(400);
    wait_model(2, 5, "ab_fill");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_drain_init", int'(state_out), 4);
    for (int s = 120; s >= 10; s -= 10) begin
      sensor = 10'(s);
      tick();
    end
    check("ab_done", int'(done), 1);
    tick();
    check("ab_done_cycles", n_done, 1);

    // Illegal targets and the legal boundaries.
    clr_cnt();
    go(5);
    check("bad5_code", int'(fault_code), 3);
    clear_fault();
    go(10);
    check("bad10_code", int'(fault_code), 3);
    clear_fault();
    go(1020);
    check("bad1020_code", int'(fault_code), 3);
    clear_fault();
    check("bad_valve", n_valve, 0);
    go(1001);
    check("bad1001_code", int'(fault_code), 3);
    clear_fault();
    sensor = 10'd1010;
    go(1000);
    check("ok1000_state", int'(state_out), 1);
    wait_model(3, 5, "ok1000_hold");
    sensor = 10'd5;
    wait_model(0, 20, "ok1000_idle");

    // Drain timeout.
    sensor = 10'd250;
    go(11);
    wait_model(5, 20, "dto_drain");
    wait_model(7, DRN_TO + 5, "dto_fault");
    check("dto_code", int'(fault_code), 2);
    clear_fault();

    // Async reset mid-fill.
    sensor = 10'd50;
    go(300);
    repeat (3) tick();
    check("rst_pre_valve", int'(inlet_valve), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valve", int'(inlet_valve), 0);
    check("arst_mreset", int'(monitor_reset), 1);
    check("arst_state", int'(state_out), 0);
    check("arst_code", int'(fault_code), 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
